sram_read_serializer: RTL
=========================

// Module: sram_read_serializer
// PURPOSE
//  Takes one full scratchpad row read from SRAM (NUM_COLS elements) and sends it to DRAM as
//  up to BEATS 64-bit write beats, using a valid/ready handshake.
//  This is the store-path counterpart of the load-path row assembler.
//  Each beat carries the request UUID with beat index in id[2:0] and a byte address stepping by 8.
//  Sits between the scpad SRAM read port / backend and the DRAM write request channel.
// PARAMETERS
//  NUM_COLS    32  elements per scratchpad row
//  ELEM_W      16  bits per element
//  BEAT_ELEMS  4   elements per DRAM beat (BEAT_ELEMS*ELEM_W = 64)
//  BEATS       8   NUM_COLS/BEAT_ELEMS; max beats per row, index fits id[2:0]
//  ADDR_W      32  DRAM byte address width
//  ID_W        16  request UUID width
// PORTS
//  clk            in   1                clock
//  rst            in   1                async reset, active-high
//  row_valid      in   1                SRAM row + descriptor valid
//  row_ready      out  1                serializer can accept a row this cycle
//  row_data       in   NUM_COLS*ELEM_W  row; element k at [k*ELEM_W +: ELEM_W]
//  row_uuid       in   ID_W             request id; bits [2:0] must be 0
//  row_dram_addr  in   ADDR_W           byte address of beat 0 (8-byte aligned)
//  num_request    in   3                index of last beat (0..7 -> 1..8 beats)
//  dram_wr_valid  out  1                beat valid
//  dram_wr_ready  in   1                DRAM accepts beat
//  dram_wr_data   out  BEAT_ELEMS*ELEM_W  beat = row elements [4b+3:4b]
//  dram_wr_addr   out  ADDR_W           row_dram_addr + 8*b
//  dram_wr_id     out  ID_W             {row_uuid[ID_W-1:3], b[2:0]}
//  dram_wr_last   out  1                b == num_request
//  row_done       out  1                1-cycle pulse when last beat accepted
// BEHAVIOUR
//  - Reset: state IDLE, beat counter 0, holding register cleared, all outputs 0
//    (row_ready=1 after reset release). Reset mid-row drops the row with no row_done.
//  - FSM IDLE/SEND. IDLE: row_ready=1, dram_wr_valid=0. Accepting a row (row_valid&row_ready)
//    latches data, uuid, addr and num_request; counter b=0; -> SEND next cycle.
//    Latency row accept -> first dram_wr_valid = 1 cycle.
//  - SEND: dram_wr_valid=1. Beat fields come from registered state only.
//    While dram_wr_ready=0 every dram_wr_* output holds stable. No beat is dropped or repeated.
//  - Beat accept (valid&ready): if b<num_request then b<=b+1, else row_done=1 that cycle.
//  - Back-to-back rows: row_ready=1 in SEND exactly when the last beat is accepted this
//    cycle. A row arriving then is latched; state stays SEND with b=0 and no idle bubble.
//    Otherwise the state -> IDLE.
//  - row_ready is combinational from state, b, num_request and dram_wr_ready. It does not
//    depend on row_valid.
//  - Address: dram_wr_addr = held_addr + {b,3'b000}, computed at ADDR_W bits with wraparound.
//    Counter b is 3 bits. num_request=7 ends at b=7 with no overflow.
//  - Beats beyond num_request are never issued. Elements of the row past beat num_request
//    are ignored.
//  - row_uuid[2:0] is ignored and replaced by b. Inputs are don't-care when row_valid=0.
// STRUCTURE
//  - scpad_pkg: scpad_data_t (row), dram_beat_t (64-bit), dram_wr_req_t
//    {valid,id,addr,data,last}, constant BEAT_BYTES=8.
//  - Sub-modules: none. Beat select is an inline indexed part-select of the held row.
//  - Counterpart of sram_write_latch: DRAM id[2:0] / 4-element-per-beat mapping is identical.
// TESTING
//  1 reset: assert rst mid-SEND at b=3 -> next cycle dram_wr_valid=0, row_ready=1, no row_done.
//  2 single row: num_request=7, addr=0x1000, uuid=0x0A8, ready=1
//    -> 8 beats on consecutive cycles; id 0x0A8..0x0AF; addr 0x1000..0x1038;
//       data[15:0] of beat 2 = element 8; last and row_done on beat 7 only.
//  3 backpressure: ready toggles 1,0,0,1 -> outputs frozen during ready=0;
//    beat count still 8; no duplicate ids.
//  4 short row: num_request=0 -> exactly 1 beat, last=1, row_done pulse,
//    row_ready=1 in that same cycle.
//  5 back-to-back: second row_valid held high during row A -> accepted on A's last-beat cycle;
//    B beat 0 follows A beat 7 with zero gap cycles.
//  6 address wrap: addr=0xFFFFFFF8, num_request=1 -> beat addrs 0xFFFFFFF8, 0x00000000.

Source files
------------

// File: rtl/scpad_pkg.sv
// Shared types and geometry for the scratchpad <-> DRAM row movers.
// A row is NUM_COLS elements; a DRAM beat carries BEAT_ELEMS of them (64 bits).
package scpad_pkg;

  localparam int NUM_COLS   = 32;
  localparam int ELEM_W     = 16;
  localparam int BEAT_ELEMS = 4;
  localparam int BEATS      = NUM_COLS / BEAT_ELEMS;
  localparam int ADDR_W     = 32;
  localparam int ID_W       = 16;
  localparam int BEAT_W     = BEAT_ELEMS * ELEM_W;
  localparam int ROW_W      = NUM_COLS * ELEM_W;
  localparam int BEAT_IDX_W = 3;
  localparam int BEAT_BYTES = 8;

  typedef logic [ROW_W-1:0]  scpad_data_t;
  typedef logic [BEAT_W-1:0] dram_beat_t;

  typedef struct packed {
    logic              valid;
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    dram_beat_t        data;
    logic              last;
  } dram_wr_req_t;

  // Byte address of beat b; wraps at ADDR_W bits.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [BEAT_IDX_W-1:0] b);
    return base + {{(ADDR_W-BEAT_IDX_W-3){1'b0}}, b, 3'b000};
  endfunction

endpackage

// File: rtl/sram_read_serializer.sv
// Serializes one scratchpad row into up to eight 64-bit DRAM write beats
// over a valid/ready channel, with back-to-back row acceptance on the last beat.
module sram_read_serializer
  import scpad_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  row_valid,
  output logic                  row_ready,
  input  logic [ROW_W-1:0]      row_data,
  input  logic [ID_W-1:0]       row_uuid,
  input  logic [ADDR_W-1:0]     row_dram_addr,
  input  logic [BEAT_IDX_W-1:0] num_request,
  output logic                  dram_wr_valid,
  input  logic                  dram_wr_ready,
  output logic [BEAT_W-1:0]     dram_wr_data,
  output logic [ADDR_W-1:0]     dram_wr_addr,
  output logic [ID_W-1:0]       dram_wr_id,
  output logic                  dram_wr_last,
  output logic                  row_done
);

  // state | meaning
  // IDLE  | no row held, waiting for row_valid
  // SEND  | presenting beat beat_q of the held row
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [BEAT_IDX_W-1:0] beat_q, beat_d;
  scpad_data_t           row_q, row_d;
  logic [ID_W-1:0]       uuid_q, uuid_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [BEAT_IDX_W-1:0] nreq_q, nreq_d;

  logic         sending;
  logic         is_last;
  logic         beat_acc;
  logic         row_acc;
  dram_wr_req_t req;

  assign sending  = (state_q == SEND);
  assign is_last  = (beat_q == nreq_q);
  assign beat_acc = sending && dram_wr_ready;

  // A new row may slip in on the cycle the final beat leaves, so there is no bubble.
  assign row_ready = !sending || (beat_acc && is_last);
  assign row_acc   = row_valid && row_ready;
  assign row_done  = beat_acc && is_last;

  always_comb begin
    req       = '0;
    req.valid = sending;
    req.id    = {uuid_q[ID_W-1:BEAT_IDX_W], beat_q};
    req.addr  = beat_addr(addr_q, beat_q);
    req.data  = row_q[{beat_q, 6'b000000} +: BEAT_W];
    req.last  = sending && is_last;
  end

  assign dram_wr_valid = req.valid;
  assign dram_wr_id    = req.id;
  assign dram_wr_addr  = req.addr;
  assign dram_wr_data  = req.data;
  assign dram_wr_last  = req.last;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    row_d   = row_q;
    uuid_d  = uuid_q;
    addr_d  = addr_q;
    nreq_d  = nreq_q;
    if (row_acc) begin
      state_d = SEND;
      beat_d  = '0;
      row_d   = row_data;
      uuid_d  = row_uuid;
      addr_d  = row_dram_addr;
      nreq_d  = num_request;
    end else if (beat_acc) begin
      if (is_last) begin
        state_d = IDLE;
      end else begin
        beat_d = beat_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      row_q   <= '0;
      uuid_q  <= '0;
      addr_q  <= '0;
      nreq_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      row_q   <= row_d;
      uuid_q  <= uuid_d;
      addr_q  <= addr_d;
      nreq_q  <= nreq_d;
    end
  end

endmodule
